bht_controller: RTL and testbench

- Sequences a shared branch-history table (BHT) of 2-bit saturating counters, indexed by a branch index.
- The table has one port, so the block arbitrates between prediction lookups from fetch and resolved-branch updates from execute.
- Updates are buffered in a small queue and applied as a two-cycle read-modify-write.
- Owns table initialisation after reset and on flush, sweeping every entry to a known value.

---
 rtl/bht_pkg.sv | 26 ++
 rtl/bht_table.sv | 28 ++
 rtl/bht_controller.sv | 165 ++++++++++++++++
 tb/tb_bht_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch-history table controller.
// Holds the FSM state encoding and the 2-bit saturating counter update.
package bht_pkg;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        UPD_RD,
        UPD_WR
    } state_e;

    localparam int CTR_W = 2;
    localparam logic [CTR_W-1:0] CTR_MAX = 2'b11;

    function automatic logic [CTR_W-1:0] sat_update(
        input logic [CTR_W-1:0] ctr,
        input logic             taken
    );
        if (taken && ctr != CTR_MAX)
            return ctr + 1'b1;
        else if (!taken && ctr != '0)
            return ctr - 1'b1;
        return ctr;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Single-port table of 2-bit counters.
// Reads return on the following cycle; a write cycle leaves rdata unchanged.
module bht_table
    import bht_pkg::*;
#(
    parameter int INDEX_W = 4
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [INDEX_W-1:0] addr,
    input  logic [CTR_W-1:0]   wdata,
    output logic [CTR_W-1:0]   rdata
);

    logic [CTR_W-1:0] mem [2**INDEX_W];

    // One access per cycle: either write the entry or register its contents.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                mem[addr] <= wdata;
            else
                rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bht_controller.sv
// Arbitrates the single BHT port between fetch lookups and queued updates.
// Also sweeps the table to INIT_CTR after reset and on flush.
module bht_controller
    import bht_pkg::*;
#(
    parameter int               INDEX_W  = 4,
    parameter int               QDEPTH   = 4,
    parameter logic [CTR_W-1:0] INIT_CTR = 2'b00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               pred_req,
    input  logic [INDEX_W-1:0] pred_idx,
    output logic               pred_ready,
    output logic               pred_valid,
    output logic               pred_taken,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_idx,
    input  logic               upd_taken,
    output logic               upd_ready,
    output logic               init_busy
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    typedef struct packed {
        logic [INDEX_W-1:0] idx;
        logic               taken;
    } upd_t;

    state_e             state;
    logic [INDEX_W-1:0] sweep_idx;
    logic [CW-1:0]      count;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    upd_t               fifo [QDEPTH];
    upd_t               cur;
    logic [CTR_W-1:0]   new_ctr;
    logic               taken_hold;

    logic               t_en;
    logic               t_we;
    logic [INDEX_W-1:0] t_addr;
    logic [CTR_W-1:0]   t_wdata;
    logic [CTR_W-1:0]   t_rdata;
    logic               pred_fire;
    logic               pop;
    logic               push;

    assign init_busy  = (state == INIT);
    assign pred_ready = (state == RUN) && (count != FULL);
    assign upd_ready  = (state != INIT) && (count != FULL);
    assign push       = upd_valid && upd_ready && !flush;
    assign pred_taken = pred_valid ? t_rdata[1] : taken_hold;

    // Port arbitration: sweep, then lookups ahead of queued updates.
    always_comb begin
        t_en      = 1'b0;
        t_we      = 1'b0;
        t_addr    = sweep_idx;
        t_wdata   = INIT_CTR;
        pred_fire = 1'b0;
        pop       = 1'b0;
        if (!flush) begin
            unique case (state)
                INIT: begin
                    t_en = 1'b1;
                    t_we = 1'b1;
                end
                RUN: begin
                    if (pred_req && pred_ready) begin
                        pred_fire = 1'b1;
                        t_en      = 1'b1;
                        t_addr    = pred_idx;
                    end else if (count != '0) begin
                        pop    = 1'b1;
                        t_en   = 1'b1;
                        t_addr = fifo[rd_ptr].idx;
                    end
                end
                UPD_RD: begin
                end
                UPD_WR: begin
                    t_en    = 1'b1;
                    t_we    = 1'b1;
                    t_addr  = cur.idx;
                    t_wdata = new_ctr;
                end
            endcase
        end
    end

    // FSM, sweep counter, queue pointers and prediction output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            sweep_idx  <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cur        <= '0;
            new_ctr    <= '0;
            pred_valid <= 1'b0;
            taken_hold <= 1'b0;
        end else begin
            pred_valid <= pred_fire;
            if (pred_valid)
                taken_hold <= t_rdata[1];
            if (flush) begin
                state     <= INIT;
                sweep_idx <= '0;
                count     <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
            end else begin
                unique case (state)
                    INIT: begin
                        sweep_idx <= sweep_idx + 1'b1;
                        if (sweep_idx == '1)
                            state <= RUN;
                    end
                    RUN: begin
                        if (pop) begin
                            cur   <= fifo[rd_ptr];
                            state <= UPD_RD;
                        end
                    end
                    UPD_RD: begin
                        new_ctr <= sat_update(t_rdata, cur.taken);
                        state   <= UPD_WR;
                    end
                    UPD_WR: begin
                        state <= RUN;
                    end
                endcase
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage; entries need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= '{idx: upd_idx, taken: upd_taken};
    end

    bht_table #(
        .INDEX_W(INDEX_W)
    ) u_table (
        .clk  (clk),
        .en   (t_en),
        .we   (t_we),
        .addr (t_addr),
        .wdata(t_wdata),
        .rdata(t_rdata)
    );

endmodule

// File: tb/tb_bht_controller.sv
// Directed bench for bht_controller: init sweep, counter updates,
// arbitration, flush and asynchronous reset behaviour.
module tb_bht_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       pred_req = 1'b0;
    logic [3:0] pred_idx = '0;
    logic       pred_ready;
    logic       pred_valid;
    logic       pred_taken;
    logic       upd_valid = 1'b0;
    logic [3:0] upd_idx = '0;
    logic       upd_taken = 1'b0;
    logic       upd_ready;
    logic       init_busy;

    int checks = 0;
    int failures = 0;

    bht_controller #(
        .INDEX_W (4),
        .QDEPTH  (4),
        .INIT_CTR(2'b00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .pred_req  (pred_req),
        .pred_idx  (pred_idx),
        .pred_ready(pred_ready),
        .pred_valid(pred_valid),
        .pred_taken(pred_taken),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx),
        .upd_taken (upd_taken),
        .upd_ready (upd_ready),
        .init_busy (init_busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pv"}, pred_valid, 0);
        chk({tag, "_pt"}, pred_taken, 0);
        chk({tag, "_pr"}, pred_ready, 0);
        chk({tag, "_ur"}, upd_ready, 0);
        chk({tag, "_ib"}, init_busy, 1);
    endtask

    task automatic wait_init(input string tag, input int exp);
        int n = 0;
        while (init_busy && n < 100) begin
            tick();
            n++;
        end
        chk(tag, n, exp);
    endtask

    task automatic lookup(input string tag, input logic [3:0] idx,
                          input logic exp);
        int n = 0;
        while (!pred_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, pred_ready, 1);
        pred_req = 1'b1;
        pred_idx = idx;
        tick();
        pred_req = 1'b0;
        chk({tag, "_vld"}, pred_valid, 1);
        chk(tag, pred_taken, exp);
        tick();
        chk({tag, "_pulse"}, pred_valid, 0);
    endtask

    task automatic push(input logic [3:0] idx, input logic taken);
        int n = 0;
        while (!upd_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push_rdy", upd_ready, 1);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = taken;
        tick();
        upd_valid = 1'b0;
    endtask

    // Directed sequence with hand-computed expectations.
    initial begin
        int n;
        tick();
        tick();
        chk_reset("rst0");
        rst = 1'b0;
        wait_init("init_len", 16);
        lookup("t1_idx3", 4'd3, 1'b0);

        // Saturating counter on idx 3: 0 -> 2 -> 3 -> 2 -> 1.
        push(4'd3, 1'b1);
        push(4'd3, 1'b1);
        idle(8);
        lookup("t2_ctr2", 4'd3, 1'b1);
        push(4'd3, 1'b1);
        push(4'd3, 1'b1);
        idle(8);
        lookup("t2_sat3", 4'd3, 1'b1);
        push(4'd3, 1'b0);
        idle(5);
        lookup("t2_dec2", 4'd3, 1'b1);
        push(4'd3, 1'b0);
        idle(5);
        lookup("t2_dec1", 4'd3, 1'b0);

        // Continuous lookups fill the queue; full queue forces a drain.
        pred_req = 1'b1;
        pred_idx = 4'd0;
        push(4'd8, 1'b1);
        chk("t3_pv", pred_valid, 1);
        push(4'd9, 1'b1);
        push(4'd8, 1'b1);
        push(4'd9, 1'b1);
        chk("t3_full_pr", pred_ready, 0);
        chk("t3_full_ur", upd_ready, 0);
        n = 0;
        while (!pred_ready && n < 20) begin
            tick();
            n++;
        end
        chk("t3_resume", n, 3);
        pred_req = 1'b0;
        idle(12);
        lookup("t3_idx8", 4'd8, 1'b1);
        lookup("t3_idx9", 4'd9, 1'b1);
        lookup("t3_idx10", 4'd10, 1'b0);

        // Same-cycle lookup and update: lookup sees the old value.
        pred_req  = 1'b1;
        pred_idx  = 4'd9;
        upd_valid = 1'b1;
        upd_idx   = 4'd9;
        upd_taken = 1'b0;
        tick();
        pred_req  = 1'b0;
        upd_valid = 1'b0;
        chk("t4_pv", pred_valid, 1);
        chk("t4_old", pred_taken, 1);
        chk("t4_run", pred_ready, 1);
        tick();
        chk("t4_pop", pred_ready, 0);
        idle(4);
        lookup("t4_new", 4'd9, 1'b0);

        // Flush during UPD_WR suppresses the write and re-sweeps.
        push(4'd5, 1'b1);
        push(4'd5, 1'b1);
        idle(8);
        lookup("t5_set", 4'd5, 1'b1);
        push(4'd5, 1'b1);
        tick();
        tick();
        chk("t5_wr_pr", pred_ready, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_ib", init_busy, 1);
        chk("t5_ur", upd_ready, 0);
        wait_init("t5_sweep", 16);
        chk("t5_empty", upd_ready, 1);
        lookup("t5_idx5", 4'd5, 1'b0);

        // Held prediction, then reset in the middle of a sweep.
        push(4'd7, 1'b1);
        push(4'd7, 1'b1);
        idle(8);
        lookup("t6_set", 4'd7, 1'b1);
        chk("t6_hold", pred_taken, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle(7);
        chk("t6_mid", init_busy, 1);
        rst = 1'b1;
        #1;
        chk_reset("rst1");
        tick();
        rst = 1'b0;
        wait_init("t6_sweep", 16);
        lookup("t6_idx7", 4'd7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
